// File: rtl/fg_reset_sequencer.sv
// fg_reset_sequencer
//   Consumer-side end of the DDSFG reset chain, clocked by the PLL output clock.
//   Qualifies the PLL lock flag, then releases the DDS core reset followed by the
//   DAC interface reset. On lock loss both resets are re-asserted and a relock
//   request is held towards the reset generator for a fixed time.
//
// Optional feature macro: FG_LOCK_LOSS_CNT_EN (adds o_lock_loss_cnt).
//
// Ports
//   i_fg_clk         in   1  PLL output clock (Fg_CLK), sole clock
//   i_fg_resetn      in   1  async active-low reset (Fg_RESETn)
//   i_pll_locked     in   1  PLL lock flag, asynchronous (PllLocked)
//   o_dds_resetn     out  1  active-low reset to DDS accumulator / LUT (Dds_RESETn)
//   o_dac_resetn     out  1  active-low reset to DAC interface (Dac_RESETn)
//   o_fg_ready       out  1  all stages released and running (Fg_Ready)
//   o_relock_req     out  1  PLL re-reset request after lock loss (Relock_Req)
//   o_lock_loss_cnt  out  8  saturating lock-loss count (LockLossCnt, macro only)

module fg_reset_sequencer #(
  parameter logic [15:0] LOCK_STABLE_CYC = 16'd1000,
  parameter logic [7:0]  STAGE_GAP_CYC   = 8'd16,
  parameter logic [7:0]  RELOCK_HOLD_CYC = 8'd64
) (
  input  logic       i_fg_clk,
  input  logic       i_fg_resetn,
  input  logic       i_pll_locked,
  output logic       o_dds_resetn,
  output logic       o_dac_resetn,
  output logic       o_fg_ready,
  output logic       o_relock_req
`ifdef FG_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] o_lock_loss_cnt
`endif
);

  localparam int unsigned CNT_W = 16;

  // Terminal counts: each counter runs 0..N-1 and the state advances on N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST = LOCK_STABLE_CYC - 16'd1;
  localparam logic [CNT_W-1:0] GAP_LAST  = {8'd0, STAGE_GAP_CYC} - 16'd1;
  localparam logic [CNT_W-1:0] HOLD_LAST = {8'd0, RELOCK_HOLD_CYC} - 16'd1;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_REL_DDS   = 3'd1,
    S_REL_DAC   = 3'd2,
    S_RUN       = 3'd3,
    S_LOST      = 3'd4
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_locked;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dds_resetn;
  logic             r_dac_resetn;
  logic             r_fg_ready;
  logic             r_relock_req;
  logic             w_dds_nxt;
  logic             w_dac_nxt;
  logic             w_ready_nxt;
  logic             w_relock_nxt;
  logic             w_lost_entry;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge i_fg_clk or negedge i_fg_resetn) begin
    if (!i_fg_resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_locked = r_sync2;

  // State, stage counter and registered outputs.
  always_ff @(posedge i_fg_clk or negedge i_fg_resetn) begin
    if (!i_fg_resetn) begin
      r_state      <= S_WAIT_LOCK;
      r_cnt        <= '0;
      r_dds_resetn <= 1'b0;
      r_dac_resetn <= 1'b0;
      r_fg_ready   <= 1'b0;
      r_relock_req <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dds_resetn <= w_dds_nxt;
      r_dac_resetn <= w_dac_nxt;
      r_fg_ready   <= w_ready_nxt;
      r_relock_req <= w_relock_nxt;
    end
  end

  // Next-state / counter logic; lock loss is checked before any stage advance.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    unique case (r_state)
      S_WAIT_LOCK: begin
        if (!w_locked) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = S_REL_DDS;
          w_cnt_nxt   = '0;
        end
      end
      S_REL_DDS: begin
        if (!w_locked) begin
          w_state_nxt = S_LOST;
          w_cnt_nxt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_REL_DAC;
          w_cnt_nxt   = '0;
        end
      end
      S_REL_DAC: begin
        if (!w_locked) begin
          w_state_nxt = S_LOST;
          w_cnt_nxt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        // Counter is parked at zero while running.
        w_cnt_nxt = '0;
        if (!w_locked) begin
          w_state_nxt = S_LOST;
        end
      end
      S_LOST: begin
        // Lock flag is ignored here; the relock hold always runs to completion.
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs move on the same edge as the state.
  always_comb begin
    w_dds_nxt    = 1'b0;
    w_dac_nxt    = 1'b0;
    w_ready_nxt  = 1'b0;
    w_relock_nxt = 1'b0;
    unique case (w_state_nxt)
      S_REL_DDS: begin
        w_dds_nxt = 1'b1;
      end
      S_REL_DAC: begin
        w_dds_nxt = 1'b1;
        w_dac_nxt = 1'b1;
      end
      S_RUN: begin
        w_dds_nxt   = 1'b1;
        w_dac_nxt   = 1'b1;
        w_ready_nxt = 1'b1;
      end
      S_LOST: begin
        w_relock_nxt = 1'b1;
      end
      default: begin
        w_dds_nxt = 1'b0;
      end
    endcase
  end

  assign w_lost_entry = (w_state_nxt == S_LOST) && (r_state != S_LOST);

  assign o_dds_resetn = r_dds_resetn;
  assign o_dac_resetn = r_dac_resetn;
  assign o_fg_ready   = r_fg_ready;
  assign o_relock_req = r_relock_req;

`ifdef FG_LOCK_LOSS_CNT_EN
  logic [7:0] r_lock_loss_cnt;

  // Saturating count of LOST entries; only the block reset clears it.
  always_ff @(posedge i_fg_clk or negedge i_fg_resetn) begin
    if (!i_fg_resetn) begin
      r_lock_loss_cnt <= 8'd0;
    end else if (w_lost_entry && (r_lock_loss_cnt != 8'hFF)) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign o_lock_loss_cnt = r_lock_loss_cnt;
`else
  logic w_lost_entry_unused;
  assign w_lost_entry_unused = w_lost_entry;
`endif

endmodule

// File: tb/tb_fg_reset_sequencer.sv
// Directed bench for fg_reset_sequencer with LOCK_STABLE_CYC=8, STAGE_GAP_CYC=4,
// RELOCK_HOLD_CYC=6. Outputs are sampled 1 time unit after each rising edge;
// "edge k" counts rising edges from the first one after reset release.
// Output vector encoding for checks: {4'b0, dds_resetn, dac_resetn, fg_ready, relock_req}.

module tb_fg_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       dds_resetn;
  logic       dac_resetn;
  logic       fg_ready;
  logic       relock_req;
`ifdef FG_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_chk;
  int n_pass;

  fg_reset_sequencer #(
    .LOCK_STABLE_CYC (16'd8),
    .STAGE_GAP_CYC   (8'd4),
    .RELOCK_HOLD_CYC (8'd6)
  ) u_dut (
    .i_fg_clk        (clk),
    .i_fg_resetn     (rst_n),
    .i_pll_locked    (locked),
    .o_dds_resetn    (dds_resetn),
    .o_dac_resetn    (dac_resetn),
    .o_fg_ready      (fg_ready),
    .o_relock_req    (relock_req)
`ifdef FG_LOCK_LOSS_CNT_EN
    ,
    .o_lock_loss_cnt (lock_loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [7:0] outs();
    return {4'b0000, dds_resetn, dac_resetn, fg_ready, relock_req};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, verify outputs clear without a clock edge, release near a falling edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, outs(), 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset just released with lock high: walk edges 0..17 of the release sequence.
  task automatic powerup_seq(input string t);
    repeat (9) step();                    // edge 8
    check({t, "_e8"}, outs(), 8'h00);
    step();                               // edge 9
    check({t, "_e9"}, outs(), 8'h08);
    repeat (3) step();                    // edge 12
    check({t, "_e12"}, outs(), 8'h08);
    step();                               // edge 13
    check({t, "_e13"}, outs(), 8'h0C);
    repeat (3) step();                    // edge 16
    check({t, "_e16"}, outs(), 8'h0C);
    step();                               // edge 17
    check({t, "_e17"}, outs(), 8'h0E);
  endtask

`ifdef FG_LOCK_LOSS_CNT_EN
  // Drive one lock loss from WAIT_LOCK through a complete relock hold.
  task automatic force_loss();
    int n;
    locked = 1'b1;
    n = 0;
    while (!dds_resetn && n < 40) begin step(); n++; end
    if (!dds_resetn) check("loss_wait_dds", 8'h00, 8'h01);
    locked = 1'b0;
    n = 0;
    while (!relock_req && n < 16) begin step(); n++; end
    if (!relock_req) check("loss_wait_relock", 8'h00, 8'h01);
    n = 0;
    while (relock_req && n < 16) begin step(); n++; end
    if (relock_req) check("loss_wait_hold", 8'h01, 8'h00);
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    locked = 1'b1;

    // Power-up: reset held with lock high.
    #2;
    check("reset_outs", outs(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    powerup_seq("pwr");

    // Loss in RUN; lock toggles during LOST, hold must still complete.
    repeat (2) step();
    check("run_steady", outs(), 8'h0E);
    locked = 1'b0;
    step();                               // e
    check("loss_e0", outs(), 8'h0E);
    step();                               // e+1
    check("loss_e1", outs(), 8'h0E);
    step();                               // e+2
    check("loss_e2", outs(), 8'h01);
    locked = 1'b1;
    repeat (2) step();                    // e+4
    locked = 1'b0;
    step();                               // e+5
    locked = 1'b1;
    check("loss_hold_e5", outs(), 8'h01);
    repeat (2) step();                    // e+7
    check("loss_hold_e7", outs(), 8'h01);
    step();                               // e+8
    check("loss_end_e8", outs(), 8'h00);
    repeat (7) step();                    // e+15
    check("relock_e15", outs(), 8'h00);
    step();                               // e+16
    check("relock_dds", outs(), 8'h08);
    repeat (4) step();
    check("relock_dac", outs(), 8'h0C);
    repeat (4) step();
    check("relock_run", outs(), 8'h0E);

    // Glitchy lock: one low cycle sampled at edge 5 restarts qualification.
    locked = 1'b1;
    do_reset("rst_glitch");
    for (int k = 0; k < 15; k++) begin
      locked = (k == 5) ? 1'b0 : 1'b1;
      step();
      check($sformatf("glitch_e%0d", k), outs(), 8'h00);
    end
    step();                               // edge 15
    check("glitch_rel", outs(), 8'h08);

    // Loss during REL_DDS: LOST wins over the stage advance at edge 13.
    locked = 1'b1;
    do_reset("rst_reldds");
    for (int k = 0; k < 22; k++) begin
      logic [7:0] exp;
      locked = (k >= 11) ? 1'b0 : 1'b1;
      step();
      if (k < 9)       exp = 8'h00;
      else if (k < 13) exp = 8'h08;
      else if (k < 19) exp = 8'h01;
      else             exp = 8'h00;
      check($sformatf("reldds_e%0d", k), outs(), exp);
    end

    // Reset at hold cycle 3 of LOST: relock request drops immediately, sequence restarts.
    locked = 1'b1;
    do_reset("rst_prelost");
    powerup_seq("pre");
    locked = 1'b0;
    repeat (3) step();                    // e+2, LOST entered
    check("mid_lost_enter", outs(), 8'h01);
    repeat (3) step();                    // hold cycle 3
    check("mid_lost_hold3", outs(), 8'h01);
    locked = 1'b1;
    do_reset("rst_mid_lost");
    powerup_seq("post");

`ifdef FG_LOCK_LOSS_CNT_EN
    locked = 1'b1;
    do_reset("rst_cnt");
    check("cnt_reset", lock_loss_cnt, 8'h00);
    for (int i = 1; i <= 300; i++) begin
      force_loss();
      if (i == 1)   check("cnt_1", lock_loss_cnt, 8'h01);
      if (i == 254) check("cnt_254", lock_loss_cnt, 8'hFE);
      if (i == 255) check("cnt_255", lock_loss_cnt, 8'hFF);
    end
    check("cnt_sat", lock_loss_cnt, 8'hFF);
    do_reset("rst_cnt_clr");
    check("cnt_clear", lock_loss_cnt, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
